// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP register scoreboard.
// Stage codes are what the FPU forwarding unit decodes.
package fpu_pkg;

    localparam logic [1:0] STG_RF  = 2'b00;
    localparam logic [1:0] STG_WB  = 2'b01;
    localparam logic [1:0] STG_MEM = 2'b10;
    localparam logic [1:0] STG_EX  = 2'b11;

    localparam int MIN_LONG_LAT = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       fpw;
    } slot_t;

    // f0 is never a real producer, so it never matches
    function automatic logic rd_hit(logic [4:0] a, logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/fpu_sb_long_tracker.sv
// Occupancy tracker for the non-pipelined FDIV/FSQRT unit.
// Counts down to zero, then steals the MEM slot for one advance.
module fpu_sb_long_tracker
    import fpu_pkg::*;
#(
    parameter int LAT_W   = 5,
    parameter int MIN_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance_i,
    input  logic             load_i,
    input  logic [4:0]       rd_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic             busy_o,
    output logic [4:0]       rd_o,
    output logic [LAT_W-1:0] cnt_o,
    output logic             wb_sel_o
);

    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);

    logic             busy_q, busy_d;
    logic [4:0]       rd_q, rd_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_c;

    assign lat_c    = (lat_i < MIN_L) ? MIN_L : lat_i;
    assign wb_sel_o = busy_q && (cnt_q == '0);

    // a load in the writeback cycle wins over the clear
    always_comb begin
        busy_d = busy_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (advance_i) begin
            if (load_i) begin
                busy_d = 1'b1;
                rd_d   = rd_i;
                cnt_d  = lat_c;
            end else if (wb_sel_o) begin
                busy_d = 1'b0;
            end else if (busy_q) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o = busy_q;
    assign rd_o   = rd_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fpu_scoreboard.sv
// FP destination scoreboard: EX/MEM/WB slots plus the long unit.
// Drives the ID issue stall and the forwarding stage codes.
module fpu_scoreboard
    import fpu_pkg::*;
#(
    parameter int LAT_W        = 5,
    parameter int MIN_LONG_LAT = fpu_pkg::MIN_LONG_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_advance,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rs3,
    input  logic [2:0]       id_src_en,
    input  logic [4:0]       id_rd,
    input  logic             id_fp_write,
    input  logic             id_is_long,
    input  logic [LAT_W-1:0] id_long_lat,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rs3,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       rs1_stage,
    output logic [1:0]       rs2_stage,
    output logic [1:0]       rs3_stage,
    output logic             long_busy,
    output logic             long_wb_sel
);

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d, mem_d, wb_d;

    logic [4:0]       long_rd;
    logic [LAT_W-1:0] long_cnt;
    logic             src_hit, waw_hit, struct_hit, wb_resv;

    fpu_sb_long_tracker #(
        .LAT_W   (LAT_W),
        .MIN_LAT (MIN_LONG_LAT)
    ) u_long (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance_i (pipe_advance),
        .load_i    (issue & id_is_long),
        .rd_i      (id_rd),
        .lat_i     (id_long_lat),
        .busy_o    (long_busy),
        .rd_o      (long_rd),
        .cnt_o     (long_cnt),
        .wb_sel_o  (long_wb_sel)
    );

    assign src_hit = (id_src_en[0] & rd_hit(id_rs1, long_rd))
                   | (id_src_en[1] & rd_hit(id_rs2, long_rd))
                   | (id_src_en[2] & rd_hit(id_rs3, long_rd));
    assign waw_hit = id_fp_write & rd_hit(id_rd, long_rd);
    // the unit frees itself in the writeback cycle
    assign struct_hit = id_is_long & ~long_wb_sel;
    // keep EX empty so the long result can take MEM next cycle
    assign wb_resv = (long_cnt == LAT_W'(1));

    assign stall = id_valid & long_busy
                 & (src_hit | waw_hit | struct_hit | wb_resv);
    assign issue = id_valid & ~stall & ~flush & pipe_advance;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (pipe_advance) begin
            wb_d  = mem_q;
            mem_d = long_wb_sel ? '{1'b1, long_rd, 1'b1} : ex_q;
            ex_d  = (issue & ~id_is_long)
                  ? '{1'b1, id_rd, id_fp_write} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    function automatic logic [1:0] stage_of(logic [4:0] r);
        logic [1:0] s;
        s = STG_RF;
        if (mem_q.valid & mem_q.fpw & rd_hit(r, mem_q.rd))
            s = STG_MEM;
        else if (wb_q.valid & wb_q.fpw & rd_hit(r, wb_q.rd))
            s = STG_WB;
        else if (long_busy & rd_hit(r, long_rd))
            s = STG_EX;
        return s;
    endfunction

    assign rs1_stage = stage_of(ex_rs1);
    assign rs2_stage = stage_of(ex_rs2);
    assign rs3_stage = stage_of(ex_rs3);

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Bench for fpu_scoreboard: directed vector table, then random
// traffic against an in-flight list model, then a mid-op reset.
module tb_fpu_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pipe_advance, flush, id_valid;
    logic [4:0] id_rs1, id_rs2, id_rs3, id_rd;
    logic [2:0] id_src_en;
    logic       id_fp_write, id_is_long;
    logic [4:0] id_long_lat;
    logic [4:0] ex_rs1, ex_rs2, ex_rs3;
    logic       stall, issue, long_busy, long_wb_sel;
    logic [1:0] rs1_stage, rs2_stage, rs3_stage;

    always #5 clk = ~clk;

    fpu_scoreboard #(.LAT_W(5), .MIN_LONG_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_advance (pipe_advance),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs3       (id_rs3),
        .id_src_en    (id_src_en),
        .id_rd        (id_rd),
        .id_fp_write  (id_fp_write),
        .id_is_long   (id_is_long),
        .id_long_lat  (id_long_lat),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rs3       (ex_rs3),
        .stall        (stall),
        .issue        (issue),
        .rs1_stage    (rs1_stage),
        .rs2_stage    (rs2_stage),
        .rs3_stage    (rs3_stage),
        .long_busy    (long_busy),
        .long_wb_sel  (long_wb_sel)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st,
                           input logic is, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3,
                           input logic bz, input logic wb);
        chk({tag, ".stall"}, 8'(stall), 8'(st));
        chk({tag, ".issue"}, 8'(issue), 8'(is));
        chk({tag, ".rs1_stage"}, 8'(rs1_stage), 8'(s1));
        chk({tag, ".rs2_stage"}, 8'(rs2_stage), 8'(s2));
        chk({tag, ".rs3_stage"}, 8'(rs3_stage), 8'(s3));
        chk({tag, ".long_busy"}, 8'(long_busy), 8'(bz));
        chk({tag, ".long_wb_sel"}, 8'(long_wb_sel), 8'(wb));
    endtask

    typedef struct {
        logic       pa, fl, vld;
        logic [4:0] r1, r2, r3;
        logic [2:0] en;
        logic [4:0] rd;
        logic       fpw, lng;
        logic [4:0] lat, e1, e2, e3;
        logic       st, is;
        logic [1:0] s1, s2, s3;
        logic       bz, wb;
    } vec_t;

    function automatic vec_t mk(
        input logic pa, fl, vld,
        input logic [4:0] r1, r2, r3, input logic [2:0] en,
        input logic [4:0] rd, input logic fpw, lng,
        input logic [4:0] lat, e1, e2, e3,
        input logic st, is, input logic [1:0] s1, s2, s3,
        input logic bz, wb);
        vec_t v;
        v.pa = pa; v.fl = fl; v.vld = vld;
        v.r1 = r1; v.r2 = r2; v.r3 = r3; v.en = en;
        v.rd = rd; v.fpw = fpw; v.lng = lng; v.lat = lat;
        v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.st = st; v.is = is; v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.bz = bz; v.wb = wb;
        return v;
    endfunction

    vec_t tbl[$];

    task automatic drive(input vec_t v);
        pipe_advance = v.pa; flush = v.fl; id_valid = v.vld;
        id_rs1 = v.r1; id_rs2 = v.r2; id_rs3 = v.r3;
        id_src_en = v.en; id_rd = v.rd; id_fp_write = v.fpw;
        id_is_long = v.lng; id_long_lat = v.lat;
        ex_rs1 = v.e1; ex_rs2 = v.e2; ex_rs3 = v.e3;
    endtask

    task automatic do_reset();
        drive(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // reference model: list of in-flight producers by pipeline age
    typedef struct { bit v; bit [4:0] rd; bit f; } ent_t;
    ent_t pipe[$];
    bit       l_busy;
    bit [4:0] l_rd;
    int       l_left;

    function automatic bit hit(bit [4:0] a, bit [4:0] b);
        return a != 0 && a == b;
    endfunction

    function automatic bit [1:0] ref_stage(bit [4:0] r);
        if (pipe[1].v && pipe[1].f && hit(r, pipe[1].rd)) return 2;
        if (pipe[2].v && pipe[2].f && hit(r, pipe[2].rd)) return 1;
        if (l_busy && hit(r, l_rd)) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '{0, 0, 0};
        pipe = {z, z, z};
        l_busy = 0; l_rd = 0; l_left = 0;
    endtask

    bit m_st, m_is, m_wb;

    task automatic model_eval();
        bit raw;
        m_wb = l_busy && l_left == 0;
        raw = (id_src_en[0] && hit(id_rs1, l_rd))
           || (id_src_en[1] && hit(id_rs2, l_rd))
           || (id_src_en[2] && hit(id_rs3, l_rd));
        m_st = id_valid && l_busy &&
              (raw || (id_fp_write && hit(id_rd, l_rd)) ||
               (id_is_long && !m_wb) || l_left == 1);
        m_is = id_valid && !m_st && !flush && pipe_advance;
    endtask

    task automatic model_step();
        ent_t ne, nm;
        if (!pipe_advance) return;
        ne = '{0, 0, 0};
        if (m_is && !id_is_long) ne = '{1, id_rd, id_fp_write};
        nm = m_wb ? '{1, l_rd, 1} : pipe[0];
        pipe = {ne, nm, pipe[1]};
        if (m_is && id_is_long) begin
            l_busy = 1; l_rd = id_rd;
            l_left = (id_long_lat < 2) ? 2 : int'(id_long_lat);
        end else if (m_wb) begin
            l_busy = 0;
        end else if (l_busy) begin
            l_left--;
        end
    endtask

    task automatic rand_cycle(input int i, input bit want_long);
        pipe_advance = ($urandom_range(0, 7) != 0);
        flush        = ($urandom_range(0, 9) == 0);
        id_valid     = ($urandom_range(0, 3) != 0);
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_rs3       = 5'($urandom_range(0, 7));
        id_src_en    = 3'($urandom);
        id_rd        = 5'($urandom_range(0, 7));
        id_fp_write  = ($urandom_range(0, 3) != 0);
        id_is_long   = ($urandom_range(0, 5) == 0);
        id_long_lat  = 5'($urandom_range(0, 6));
        ex_rs1       = 5'($urandom_range(0, 7));
        ex_rs2       = 5'($urandom_range(0, 7));
        ex_rs3       = 5'($urandom_range(0, 7));
        if (want_long) begin
            pipe_advance = 1; flush = 0; id_valid = 1;
            id_is_long = 1; id_long_lat = 5'd20; id_rd = 5'd9;
            id_src_en = 0;
        end
        @(negedge clk);
        model_eval();
        chk_all($sformatf("rnd%0d", i), m_st, m_is,
                ref_stage(ex_rs1), ref_stage(ex_rs2),
                ref_stage(ex_rs3), l_busy, m_wb);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // back-to-back FADD f3 -> FMUL
        tbl.push_back(mk(1,0,1, 1,2,0,3, 3,1,0,0, 0,0,0, 0,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 3,0,0,1, 4,1,0,0, 3,0,0, 0,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 3,0,0, 0,0,2,0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 3,4,0, 0,0,1,2,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 4,3,0, 0,0,1,0,0,0,0));
        // FDIV f5 lat 4, FADD rs2=f5 waits
        tbl.push_back(mk(1,0,1, 1,2,0,3, 5,1,1,4, 0,0,0, 0,1,0,0,0,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,1, 0,5,0,2, 6,1,0,0, 0,5,0,
                             1,0,0,3,0,1,0));
        tbl.push_back(mk(1,0,1, 0,5,0,2, 6,1,0,0, 0,5,0, 1,0,0,3,0,1,1));
        tbl.push_back(mk(1,0,1, 0,5,0,2, 6,1,0,0, 0,5,0, 0,1,0,2,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 6,5,0, 0,0,0,1,0,0,0));
        // FDIV f7 lat 3, then FSQRT f8
        tbl.push_back(mk(1,0,1, 1,2,0,3, 7,1,1,3, 0,0,0, 0,1,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,0,1, 9,0,0,1, 8,1,1,2, 0,0,0,
                             1,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,1, 9,0,0,1, 8,1,1,2, 0,0,0, 0,1,0,0,0,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 7,8,0, 0,0,2,3,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 7,8,0, 0,0,1,3,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,8,0, 0,0,0,3,0,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,8,0, 0,0,0,2,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,8,0, 0,0,0,1,0,0,0));
        // clamp lat 0 -> 2, then f0 in MEM never matches
        tbl.push_back(mk(1,0,1, 0,0,0,0, 10,1,1,0, 0,0,0, 0,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 10,0,0, 0,0,2,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0,0, 0,1,0,0, 10,0,0, 0,1,1,0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        // FDIV f11 lat 3, freeze 3 cycles, then flush
        tbl.push_back(mk(1,0,1, 1,2,0,3, 11,1,1,3, 0,0,0, 0,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,1, 1,0,0,1, 12,1,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,1, 11,0,0,1, 12,1,0,0, 0,0,0, 1,0,0,0,0,1,0));
        tbl.push_back(mk(1,1,1, 1,0,0,1, 13,1,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 13,0,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 11,13,0, 0,0,2,0,0,0,0));

        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].is,
                    tbl[i].s1, tbl[i].s2, tbl[i].s3,
                    tbl[i].bz, tbl[i].wb);
            @(posedge clk);
            #1;
        end

        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) rand_cycle(i, 1'b0);
        for (int i = 0; i < 12; i++) rand_cycle(600 + i, 1'b1);

        // asynchronous reset while the long op is pending
        chk("pre_rst.long_busy", 8'(long_busy), 8'(l_busy));
        id_valid = 0;
        ex_rs1 = 5'd9; ex_rs2 = 5'd9; ex_rs3 = 5'd9;
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
